// File: rtl/spi_pkg.sv
// Shared SPI types and constants.
// Holds the responder FSM state type, the fixed bus-mode constants and the
// initiator's state type so both ends of the bus share one definition.
package spi_pkg;

    // Responder frame sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } spi_slv_state_t;

    // Bus mode: SCK idles low, data sampled on the rising edge, MSB first.
    localparam int unsigned SPI_CPOL      = 0;
    localparam int unsigned SPI_CPHA      = 0;
    localparam int unsigned SPI_MSB_FIRST = 1;

    // Initiator (spi_master) sequencer states.
    typedef enum logic [1:0] {
        MST_IDLE     = 2'd0,
        MST_TRANSFER = 2'd1,
        MST_DONE     = 2'd2
    } state_t;

endpackage

// File: rtl/spi_bus_if.sv
// Four-wire SPI bus bundle.
//   spi_sck, spi_cs_n, spi_mosi : driven by the initiator
//   spi_miso                    : driven by the responder
// Modports: master (initiator view) and slave (responder view).
interface spi_bus_if;
    logic spi_sck;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sck,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sck,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_sync.sv
// N-flop level synchronizer with edge pulses.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   level      : synchronized level (last flop of the chain)
//   rise, fall : one-cycle pulses when level changes 0->1 / 1->0
// Parameters: STAGES (>= 2) flops, RESET_VAL loaded into every flop on reset.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled in the system clock domain.
// Ports:
//   clk, rst_n         : system clock, asynchronous active-low reset
//   tx_data, tx_load   : word to return and its one-cycle capture strobe
//   tx_ready           : tx holding register is empty
//   rx_data, rx_valid  : last received word and its unread flag
//   rx_ack             : CPU consumed rx_data (clears rx_valid)
//   busy               : frame in progress
//   overrun            : sticky error flag (0 unless SPI_SLAVE_OVERRUN_EN)
//   spiIF              : spi_bus_if slave view
// Build option: define SPI_SLAVE_OVERRUN_EN to build the overrun/underrun
// detector; otherwise overrun is tied low.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_LENGTH-1:0] tx_data,
    input  logic                   tx_load,
    output logic                   tx_ready,
    output logic [DATA_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ack,
    output logic                   busy,
    output logic                   overrun,
    spi_bus_if.slave               spiIF
);

    localparam int unsigned CNT_W = $clog2(DATA_LENGTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DATA_LENGTH);

    // Conditioned bus inputs
    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_level_unused, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spiIF.spi_sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // CS_n idles high so reset must not look like a frame start.
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spiIF.spi_cs_n),
        .level (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spiIF.spi_mosi),
        .level (mosi_sync),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    // State
    spi_slv_state_t         state_q, state_d;
    logic [DATA_LENGTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_LENGTH-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       bit_count_q, bit_count_d;
    logic [DATA_LENGTH-1:0] hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_LENGTH-1:0] rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   miso_q, miso_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_count_q <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_count_q <= bit_count_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            miso_q      <= miso_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_count_d = bit_count_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        busy_d      = busy_q;
        miso_d      = miso_q;

        // Ack first so a coinciding commit re-asserts rx_valid.
        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    // An empty holding register sends all zeros.
                    tx_shift_d  = hold_full_q ? hold_q : '0;
                    miso_d      = hold_full_q & hold_q[DATA_LENGTH-1];
                    hold_full_d = 1'b0;
                    bit_count_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                // CS_n release takes priority over any coinciding SCK edge.
                if (cs_rise) begin
                    busy_d  = 1'b0;
                    miso_d  = 1'b0;
                    state_d = COMMIT;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_LENGTH-2:0], mosi_sync};
                        if (bit_count_q != FULL_COUNT) begin
                            bit_count_d = bit_count_q + 1'b1;
                        end
                    end
                    if (sck_fall) begin
                        // Zero fill drives MISO low once the word is exhausted.
                        tx_shift_d = {tx_shift_q[DATA_LENGTH-2:0], 1'b0};
                        miso_d     = tx_shift_q[DATA_LENGTH-2];
                    end
                end
            end
            COMMIT: begin
                // Short frames are dropped without touching rx_data.
                if (bit_count_q == FULL_COUNT) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A load in the frame-start cycle refills after the shifter took the old word.
        if (tx_load) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q, overrun_d;
    logic commit_word, frame_start;

    assign commit_word = (state_q == COMMIT) && (bit_count_q == FULL_COUNT);
    assign frame_start = (state_q == IDLE) && cs_fall;

    always_comb begin
        overrun_d = overrun_q;
        if (rx_ack) begin
            overrun_d = 1'b0;
        end
        // A new error in the ack cycle still sets the flag.
        if ((commit_word && rx_valid_q && !rx_ack) || (frame_start && !hold_full_q)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign tx_ready       = ~hold_full_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign busy           = busy_q;
    assign spiIF.spi_miso = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad   = 0;

`ifdef SPI_SLAVE_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    spi_bus_if bus ();

    spi_slave #(
        .DATA_LENGTH (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .busy     (busy),
        .overrun  (overrun),
        .spiIF    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tx_ready monitor used while a frame runs with an empty holding register.
    logic watch_ready = 1'b0;
    logic ready_dropped = 1'b0;
    always @(negedge clk) begin
        if (watch_ready && tx_ready !== 1'b1) ready_dropped = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
        wait_clk(2);
    endtask

    // Bench acts as the initiator; SCK half-period is 6 clk.
    task automatic spi_frame(input logic [7:0] word, input int nbits, input bit ack_commit,
                             output logic [7:0] got);
        got = '0;
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = (i < 8) ? word[7-i] : 1'b0;
            wait_clk(6);
            if (i < 8) got[7-i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            wait_clk(6);
            bus.spi_sck = 1'b0;
        end
        wait_clk(6);
        bus.spi_cs_n = 1'b1;
        if (ack_commit) begin
            // CS_n rise reaches COMMIT three clk later; ack lands on that cycle.
            wait_clk(3);
            rx_ack = 1'b1;
            wait_clk(1);
            rx_ack = 1'b0;
            wait_clk(8);
        end else begin
            wait_clk(12);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        tx_data      = '0;
        tx_load      = 1'b0;
        rx_ack       = 1'b0;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (bus.spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso: got %b want 0", bus.spi_miso); end
    endtask

    task automatic test_loopback();
        logic [7:0] got;
        load_tx(8'hA5);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL loop_tx_ready_loaded: got %b want 0", tx_ready); end
        spi_frame(8'h3C, 8, 1'b0, got);
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL loop_rx_data: got %h want 3c", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL loop_rx_valid: got %b want 1", rx_valid); end
        total++; if (got !== 8'hA5) begin bad++; $display("FAIL loop_miso_word: got %h want a5", got); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL loop_tx_ready_after: got %b want 1", tx_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL loop_busy_after: got %b want 0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL loop_overrun: got %b want 0", overrun); end
        pulse_ack();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL loop_ack_clears: got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        spi_frame(8'h01, 8, 1'b0, got);
        total++; if (rx_data !== 8'h01) begin bad++; $display("FAIL b2b_first: got %h want 01", rx_data); end
        spi_frame(8'hFE, 8, 1'b0, got);
        total++; if (rx_data !== 8'hFE) begin bad++; $display("FAIL b2b_rx_data: got %h want fe", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_rx_valid: got %b want 1", rx_valid); end
        total++; if (overrun !== OVR_EXP) begin bad++; $display("FAIL b2b_overrun: got %b want %b", overrun, OVR_EXP); end
        pulse_ack();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun_ack: got %b want 0", overrun); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_ack: got %b want 0", rx_valid); end
    endtask

    task automatic test_short_frame();
        logic [7:0] got;
        spi_frame(8'h00, 5, 1'b0, got);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL short_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'hFE) begin bad++; $display("FAIL short_rx_data: got %h want fe", rx_data); end
        pulse_ack();
    endtask

    task automatic test_empty_tx();
        logic [7:0] got;
        ready_dropped = 1'b0;
        watch_ready   = 1'b1;
        spi_frame(8'h77, 8, 1'b0, got);
        watch_ready   = 1'b0;
        total++; if (got !== 8'h00) begin bad++; $display("FAIL empty_miso_word: got %h want 00", got); end
        total++; if (ready_dropped !== 1'b0) begin bad++; $display("FAIL empty_tx_ready_dropped: got %b want 0", ready_dropped); end
        total++; if (rx_data !== 8'h77) begin bad++; $display("FAIL empty_rx_data: got %h want 77", rx_data); end
        pulse_ack();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        load_tx(8'h96);
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.spi_mosi = 1'b1;
            wait_clk(6);
            bus.spi_sck = 1'b1;
            wait_clk(6);
            bus.spi_sck = 1'b0;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before_reset: got %b want 1", busy); end
        rst_n = 1'b0;
        wait_clk(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_tx_ready: got %b want 1", tx_ready); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_rx_valid: got %b want 0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data: got %h want 00", rx_data); end
        total++; if (bus.spi_miso !== 1'b0) begin bad++; $display("FAIL mid_miso: got %b want 0", bus.spi_miso); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun: got %b want 0", overrun); end
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL mid_no_commit: got %b want 0", rx_valid); end
        spi_frame(8'h5A, 8, 1'b0, got);
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL mid_next_rx_data: got %h want 5a", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL mid_next_rx_valid: got %b want 1", rx_valid); end
        total++; if (got !== 8'h00) begin bad++; $display("FAIL mid_next_miso: got %h want 00", got); end
    endtask

    // rx_valid is still 1 from the previous frame on entry.
    task automatic test_sck_idle_ack_commit();
        logic [7:0] got;
        bus.spi_mosi = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_clk(6);
            bus.spi_sck = 1'b1;
            wait_clk(6);
            bus.spi_sck = 1'b0;
        end
        wait_clk(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_sck_busy: got %b want 0", busy); end
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL idle_sck_rx_data: got %h want 5a", rx_data); end
        load_tx(8'h3C);
        spi_frame(8'hC3, 8, 1'b1, got);
        total++; if (rx_data !== 8'hC3) begin bad++; $display("FAIL ackc_rx_data: got %h want c3", rx_data); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ackc_rx_valid: got %b want 1", rx_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ackc_overrun: got %b want 0", overrun); end
        total++; if (got !== 8'h3C) begin bad++; $display("FAIL ackc_miso_word: got %h want 3c", got); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_short_frame();
        test_empty_tx();
        test_reset_mid_frame();
        test_sck_idle_ack_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
